// File: rtl/regfile_pkg.sv
// Shared defaults and well-known register numbers for the register file.
// Holds no logic; imported by the storage top and the busy scoreboard.
package regfile_pkg;

    localparam int DW_DEF     = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int NUM_RD_DEF = 2;

    // Hardwired-zero register number.
    localparam int REG_ZERO = 0;
    // Return-address register, written by the link path on write port 1.
    localparam int REG_RA   = DEPTH_DEF - 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback.
// Ports: clk, rst (sync, active-low), sb_set_*, wrN_{en,clr,addr}, busy_vec.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sb_set_en,
    input  logic [AW-1:0]    sb_set_addr,
    input  logic             wr0_en,
    input  logic             wr0_clr,
    input  logic [AW-1:0]    wr0_addr,
    input  logic             wr1_en,
    input  logic             wr1_clr,
    input  logic [AW-1:0]    wr1_addr,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // A set beats a same-cycle clear: a new producer was just issued.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_set_en && sb_set_addr == AW'(i)) begin
                w_busy_nxt[i] = 1'b1;
            end else if ((wr0_en && wr0_clr && wr0_addr == AW'(i)) ||
                         (wr1_en && wr1_clr && wr1_addr == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised
// writes, optional bypass / zero register, busy scoreboard, debug read.
// Ports: clk, rst (sync, active-low), rd_addr/rd_data/rd_busy,
// wr0_*/wr1_*, sb_set_*, busy_vec, dbg_addr/dbg_data.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int DBG_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic                 wr0_clr,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr1_data,
    input  logic                 wr1_clr,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    output logic [DEPTH-1:0]     busy_vec,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr0_ok;
    logic          w_wr1_ok;

    // Writes to the hardwired zero register are dropped at the source.
    assign w_wr0_ok = wr0_en &&
        !(ZERO_REG != 0 && wr0_addr == AW'(REG_ZERO));
    assign w_wr1_ok = wr1_en &&
        !(ZERO_REG != 0 && wr1_addr == AW'(REG_ZERO));

    // Port 1 is applied last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr0_ok) begin
                r_mem[wr0_addr] <= wr0_data;
            end
            if (w_wr1_ok) begin
                r_mem[wr1_addr] <= wr1_data;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .wr0_en      (wr0_en),
        .wr0_clr     (wr0_clr),
        .wr0_addr    (wr0_addr),
        .wr1_en      (wr1_en),
        .wr1_clr     (wr1_clr),
        .wr1_addr    (wr1_addr),
        .busy_vec    (busy_vec)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;

        assign w_addr = rd_addr[k*AW +: AW];

        always_comb begin
            w_data = r_mem[w_addr];
            if (BYPASS != 0) begin
                if (wr1_en && wr1_addr == w_addr) begin
                    w_data = wr1_data;
                end else if (wr0_en && wr0_addr == w_addr) begin
                    w_data = wr0_data;
                end
            end
            if (ZERO_REG != 0 && w_addr == AW'(REG_ZERO)) begin
                w_data = '0;
            end
        end

        assign rd_data[k*DW +: DW] = w_data;
        // Registered busy only: no lookahead of this cycle's set/clear.
        assign rd_busy[k] = busy_vec[w_addr];
    end

    assign dbg_data = (DBG_EN != 0) ? r_mem[dbg_addr] : '0;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-port-pair CPU register file.
- Generalised data width and depth; NUM_RD combinational read ports; two write ports with fixed priority; optional write-to-read bypass; optional hardwired zero register.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) so the decode stage can detect RAW hazards.
- Sits between decode (reads, scoreboard set) and writeback (two writes, scoreboard clear).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers (power of two, ≥2).
- AW, $clog2(DEPTH), address width (derived; do not override).
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on the read data.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.
- DBG_EN, 1, 1 = debug read port is active; 0 = dbg_data is tied to 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy  out  NUM_RD  port k reads a register with its busy bit set (bypass does not clear it).
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  AW  write port 0 address.
- wr0_data  in  DW  write port 0 data.
- wr0_clr  in  1  write port 0 also clears the busy bit of wr0_addr.
- wr1_en, wr1_addr, wr1_data, wr1_clr  in  1/AW/DW/1  write port 1 (load/link writeback); same meaning as port 0.
- sb_set_en  in  1  issue: mark sb_set_addr busy.
- sb_set_addr  in  AW  register to mark busy.
- busy_vec  out  DEPTH  all busy bits, bit i = register i.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DW  debug read data, unbypassed.

Behaviour:
- Reset: while rst==0 at a clk edge, all registers are set to 0 and all busy bits to 0.
  - Any write or busy set presented in that cycle is dropped.
  - After reset, rd_data, dbg_data, rd_busy and busy_vec all read 0.
- Reads are combinational, with zero-cycle latency. Writes commit at the clk edge; latency to storage is 1.
- Bypass, BYPASS=1, per read port k:
  - if wr1_en and wr1_addr == rd_addr_k, rd_data_k = wr1_data;
  - else if wr0_en and wr0_addr == rd_addr_k, rd_data_k = wr0_data;
  - else rd_data_k = stored value.
- Bypass, BYPASS=0: rd_data_k = stored value only; a write appears the cycle after.
- Same-address dual write: port 1 wins; port 0 data is discarded.
- ZERO_REG=1, address 0:
  - writes are ignored, bypass included, and rd_data is 0;
  - the busy bit is never set, and rd_busy is 0.
- ZERO_REG=0: register 0 behaves like any other register.
- Scoreboard, per register i at each clk edge (rst high):
  - set = sb_set_en && sb_set_addr == i;
  - clr = (wr0_en && wr0_clr && wr0_addr == i) || (wr1_en && wr1_clr && wr1_addr == i);
  - next busy[i] = set ? 1 : (clr ? 0 : busy[i]).
  - Set wins over a simultaneous clear: a new producer has been issued.
- wrN_clr with wrN_en==0 has no effect.
- A write with wrN_clr==0 updates data and leaves the busy bit unchanged.
- rd_busy_k = busy[rd_addr_k], taken from the registered bits only, with no lookahead of this cycle's set or clear.
- dbg_data = stored[dbg_addr], with no bypass, when DBG_EN=1; otherwise it is 0.
- Addresses are always in range by construction: DEPTH is a power of two, so there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg:
  - defaults for DW, DEPTH and NUM_RD;
  - localparam REG_ZERO=0;
  - localparam REG_RA=DEPTH-1, used by the link write on port 1.
- One natural sub-module: regfile_scoreboard, holding the busy bits and the set/clear/priority logic with the busy_vec output.
- Storage, bypass and debug read stay in regfile_mp. Read ports are built with a generate loop.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr0_en=1, wr0_addr=5, wr0_data=0xDEAD → after release, rd_data port0 (addr 5)=0 and busy_vec=0.
- Bypass: with BYPASS=1, wr0 addr 7 data 0x1234 and port0 reading addr 7 in the same cycle → rd_data=0x1234 combinationally.
  - Repeat with BYPASS=0 → old value 0 that cycle, 0x1234 the next.
- Dual write to addr 3: wr0 data 0xAAAA, wr1 data 0x5555 → stored value and bypass output both 0x5555.
- Zero register: write 0xFFFF_FFFF to addr 0 and sb_set_addr=0 → rd_data=0, rd_busy=0 and busy_vec[0]=0.
  - With ZERO_REG=0, the same stimulus gives 0xFFFF_FFFF and busy.
- Scoreboard: set addr 9 → busy_vec[9]=1 next cycle.
  - wr1 addr 9 with clr=1 and sb_set addr 9 in the same cycle → remains 1.
  - Clear alone → 0.
  - wr0 addr 9 with clr=0 → busy unchanged, data updated.
- Reset mid-operation: busy bits 2, 4 and 31 set and registers written, then rst=0 for one cycle with sb_set_en=1 → all data and busy bits are 0, and the set is dropped.
